// File: rtl/prototipo_uwu.sv
// prototipo_uwu: unipolar stepper phase sequencer with prescaled step rate
module prototipo_uwu #(
   parameter int STEP_DIV  = 50000,
   parameter int DIV_WIDTH = 16,
   parameter int HALF_STEP = 0,
   parameter int DIR       = 1
) (
   input  logic enable,
   input  logic clk,
   output logic coil_a,
   output logic coil_b,
   output logic coil_c,
   output logic coil_d,
   input  logic rst_n
);
   localparam int IW = HALF_STEP ? 3 : 2;
   localparam logic [31:0] HS = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0100, 4'b1100, 4'b1000};
   logic [DIV_WIDTH-1:0] presc;
   logic [IW-1:0] idx;
   logic [3:0] coils;
   logic [3:0] pat;
   logic [2:0] i3;
   logic wrap;
   assign i3 = 3'(idx);
   assign wrap = presc == DIV_WIDTH'(STEP_DIV - 1);
   assign {coil_a, coil_b, coil_c, coil_d} = coils;
   // coil pattern for the current phase index
   always_comb pat = HALF_STEP ? HS[{i3, 2'b00} +: 4] : 4'b1000 >> i3;
   // drive held-position pattern; advance phase once per STEP_DIV enabled cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
         coils <= '0;
      end else if (enable) begin
         coils <= pat;
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) idx <= DIR ? idx + IW'(1) : idx - IW'(1);
      end else begin
         coils <= '0;
         presc <= '0;
      end
   end
endmodule

// File: tb/tb_prototipo_uwu.sv
// tb_prototipo_uwu: scoreboard bench for three sequencer configurations
module tb_prototipo_uwu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] en = 3'b000;
   logic [3:0] c0, c1, c2;
   int errors = 0;
   int checks = 0;
   logic [3:0] q0[$], q1[$], q2[$];

   always #5 clk = ~clk;

   prototipo_uwu #(.STEP_DIV(4), .DIV_WIDTH(16), .HALF_STEP(0), .DIR(1)) u0 (
      .enable(en[0]), .clk(clk), .coil_a(c0[3]), .coil_b(c0[2]), .coil_c(c0[1]), .coil_d(c0[0]), .rst_n(rst_n));
   prototipo_uwu #(.STEP_DIV(2), .DIV_WIDTH(16), .HALF_STEP(1), .DIR(0)) u1 (
      .enable(en[1]), .clk(clk), .coil_a(c1[3]), .coil_b(c1[2]), .coil_c(c1[1]), .coil_d(c1[0]), .rst_n(rst_n));
   prototipo_uwu #(.STEP_DIV(1), .DIV_WIDTH(16), .HALF_STEP(0), .DIR(1)) u2 (
      .enable(en[2]), .clk(clk), .coil_a(c2[3]), .coil_b(c2[2]), .coil_c(c2[1]), .coil_d(c2[0]), .rst_n(rst_n));

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: pop expected patterns after each edge, plus per-edge safety properties
   always @(posedge clk) begin
      logic [2:0] e;
      e = en;
      #1;
      if (q0.size() > 0) chk("seq0", c0, q0.pop_front());
      if (q1.size() > 0) chk("seq1", c1, q1.pop_front());
      if (q2.size() > 0) chk("seq2", c2, q2.pop_front());
      chk("opp0", {2'b00, c0[3] & c0[1], c0[2] & c0[0]}, 4'b0000);
      chk("opp1", {2'b00, c1[3] & c1[1], c1[2] & c1[0]}, 4'b0000);
      chk("opp2", {2'b00, c2[3] & c2[1], c2[2] & c2[0]}, 4'b0000);
      if (!e[0]) chk("off0", c0, 4'b0000);
      if (!e[1]) chk("off1", c1, 4'b0000);
      if (!e[2]) chk("off2", c2, 4'b0000);
   end

   task automatic seg(input int d, input logic e, input int n, input logic [3:0] p);
      repeat (n) begin
         en[d] = e;
         if (d == 0) q0.push_back(p);
         else if (d == 1) q1.push_back(p);
         else q2.push_back(p);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst0", c0, 4'b0000);
      chk("rst1", c1, 4'b0000);
      chk("rst2", c2, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      seg(0, 1, 4, 4'b1000);
      seg(0, 1, 4, 4'b0100);
      seg(0, 1, 4, 4'b0010);
      seg(0, 1, 4, 4'b0001);
      seg(0, 1, 4, 4'b1000);
      seg(0, 1, 4, 4'b0100);
      seg(0, 1, 2, 4'b0010);
      seg(0, 0, 1, 4'b0000);
      seg(0, 1, 4, 4'b0010);
      seg(0, 1, 4, 4'b0001);
      seg(0, 1, 4, 4'b1000);
      seg(0, 1, 4, 4'b0100);
      seg(0, 1, 1, 4'b0010);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", c0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      seg(0, 1, 4, 4'b1000);
      seg(0, 1, 1, 4'b0100);
      en[0] = 1'b0;
      seg(1, 1, 2, 4'b1000);
      seg(1, 1, 2, 4'b1001);
      seg(1, 1, 2, 4'b0001);
      seg(1, 1, 2, 4'b0011);
      seg(1, 1, 2, 4'b0010);
      seg(1, 1, 2, 4'b0110);
      seg(1, 1, 2, 4'b0100);
      seg(1, 1, 2, 4'b1100);
      seg(1, 1, 2, 4'b1000);
      en[1] = 1'b0;
      seg(2, 1, 1, 4'b1000);
      seg(2, 1, 1, 4'b0100);
      seg(2, 1, 1, 4'b0010);
      seg(2, 1, 1, 4'b0001);
      seg(2, 1, 1, 4'b1000);
      en[2] = 1'b0;
      repeat (10000) begin
         en = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      en = 3'b000;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prototipo_uwu.md
Name: prototipo_uwu

Overview:
- Unipolar stepper-motor phase sequencer driving four coil outputs.
- Parent timer FSM asserts `enable` during the dispense window and deasserts it on the sensor or on timeout.
- While enabled, the block steps through a fixed coil pattern at a rate set by a clock prescaler.
- While disabled, all coils are de-energised and the step position is held.

Parameters:
- STEP_DIV, 50000: clk cycles per motor step. Legal range 1 to 2^DIV_WIDTH-1.
- DIV_WIDTH, 16: prescaler counter width.
- HALF_STEP, 0: 0 selects the 4-state wave-drive sequence; 1 selects the 8-state half-step sequence.
- DIR, 1: 1 increments the phase index (forward); 0 decrements it (reverse).

Ports:
- clk  input  1  step clock, rising edge (codebase name clk).
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  run request. 1 means step the motor; 0 means stop and de-energise.
- coil_a  output  1  coil A drive, registered.
- coil_b  output  1  coil B drive, registered.
- coil_c  output  1  coil C drive, registered.
- coil_d  output  1  coil D drive, registered.
- Positional order matches existing instances: enable, clk, coil_a, coil_b, coil_c, coil_d, rst_n.

Behaviour:
- State:
  - prescaler `presc` [DIV_WIDTH-1:0].
  - phase index `idx`: 2 bits in wave mode, 3 bits in half-step mode.
  - 4-bit output register {coil_a, coil_b, coil_c, coil_d}.
- Reset (rst_n=0, asynchronous): presc=0, idx=0, all coils=0. Reset dominates everything, including mid-step; no clock is needed for it to take effect.
- Pattern table for {a,b,c,d}:
  - Wave mode, idx 0..3: 1000, 0100, 0010, 0001.
  - Half-step mode, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Each rising clk edge with enable=1:
  - Coils <= pattern(idx), using the pre-edge value of idx.
  - If presc == STEP_DIV-1: presc <= 0, and idx advances by ±1 per DIR, wrapping modulo the sequence length (3→0 / 0→3 in wave mode, 7→0 / 0→7 in half-step mode).
  - Otherwise presc <= presc+1.
- Each rising clk edge with enable=0: coils <= 0000, presc <= 0, idx holds.
- Timing consequences:
  - The first enabled edge drives the pattern for the held idx.
  - Each pattern persists exactly STEP_DIV cycles.
  - A pattern change appears one edge after idx advances.
- STEP_DIV=1: idx advances on every enabled edge, so the coils change every cycle.
- Enable glitch: a single-cycle enable drop clears the prescaler, restarting the full STEP_DIV dwell, and zeroes the coils for that cycle.
- Exactly one coil (wave mode) or one or two adjacent coils (half-step mode) are ever high. Opposing pairs A+C and B+D are never high together.
- No combinational path from enable to the coils.

Test Plan:
1. Reset while enabled mid-sequence (idx=2) with STEP_DIV=4 → coils 0000 immediately, without a clock edge. After release with enable=1, the first edge gives 1000.
2. Wave forward, STEP_DIV=4, enable=1 from edge 1 → 1000 on edges 1-4, 0100 on 5-8, 0010 on 9-12, 0001 on 13-16, then 1000 on edge 17 (wrap).
3. Disable after reaching 0010 with presc=2 → next edge gives 0000. Re-enable → 0010 held for a full 4 cycles, then 0001 (position retained, prescaler restarted).
4. Half-step, DIR=0, STEP_DIV=2 from reset → 1000 ×2, 1001 ×2, 0001 ×2, 0011 ×2, and so on through the reverse sequence.
5. STEP_DIV=1, wave mode → coils 1000, 0100, 0010, 0001, 1000 on consecutive enabled edges.
6. Random enable toggling over 10k cycles → assertion that A&C and B&D are never 1 together, and coils are 0000 on every edge following enable=0.
